// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared MIPS CPU state encoding and address constants
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        HALT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC1  = 3'd3,
        EXEC2  = 3'd4
    } state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_perf_counters.sv
// rtl/mips_cpu_perf_counters.sv - free-running cycle and retired-instruction counters
module mips_cpu_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             instr_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    // Both counters wrap naturally; count_en is low in HALT so they freeze there.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (count_en) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (instr_done) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_sequencer.sv
// rtl/mips_cpu_sequencer.sv - multicycle FETCH/DECODE/EXEC sequencer; MIPS_CPU_PERF_COUNTERS_EN adds debug counters
module mips_cpu_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             threecycle,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             waitrequest,
    input  logic [31:0]      pc,
    output logic [2:0]       state,
    output logic             active,
    output logic             cycle_en,
    output logic             bus_en,
    output logic             instr_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t state_q;
    state_t state_n;
    logic   stall_req;

    assign state     = state_q;
    assign stall_req = (memread | memwrite) & waitrequest;

    // State register; reset always restarts at FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and qualifiers; halt detect and illegal codes take priority over a stall.
    always_comb begin
        state_n    = state_q;
        active     = 1'b1;
        cycle_en   = 1'b0;
        bus_en     = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            HALT: begin
                active  = 1'b0;
                state_n = HALT;
            end
            FETCH: begin
                if (pc == HALT_ADDR) begin
                    state_n = HALT;
                end else begin
                    bus_en = 1'b1;
                    if (!stall_req) begin
                        cycle_en = 1'b1;
                        state_n  = DECODE;
                    end
                end
            end
            DECODE: begin
                bus_en = 1'b1;
                if (!stall_req) begin
                    cycle_en = 1'b1;
                    state_n  = EXEC1;
                end
            end
            EXEC1: begin
                bus_en = 1'b1;
                if (!stall_req) begin
                    cycle_en   = 1'b1;
                    instr_done = threecycle;
                    state_n    = threecycle ? FETCH : EXEC2;
                end
            end
            EXEC2: begin
                bus_en = 1'b1;
                if (!stall_req) begin
                    cycle_en   = 1'b1;
                    instr_done = 1'b1;
                    state_n    = FETCH;
                end
            end
            default: begin
                state_n = HALT;
            end
        endcase
        if (reset) begin
            active     = 1'b1;
            cycle_en   = 1'b0;
            bus_en     = 1'b0;
            instr_done = 1'b0;
        end
    end

`ifdef MIPS_CPU_PERF_COUNTERS_EN
    logic count_en;

    assign count_en = (state_q != HALT);

    mips_cpu_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf_counters (
        .clk        (clk),
        .reset      (reset),
        .count_en   (count_en),
        .instr_done (instr_done),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// tb/tb_mips_cpu_sequencer.sv - table-driven bench for mips_cpu_sequencer
module tb_mips_cpu_sequencer;

    localparam int          CNT_W = 32;
    localparam logic [31:0] PCV   = 32'hBFC0_0000;
    localparam int          NVEC  = 23;

`ifdef MIPS_CPU_PERF_COUNTERS_EN
    localparam logic [31:0] EXP_CYC = 32'd35;
    localparam logic [31:0] EXP_INS = 32'd10;
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
    localparam logic [31:0] EXP_INS = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             threecycle;
    logic             memread;
    logic             memwrite;
    logic             waitrequest;
    logic [31:0]      pc;
    logic [2:0]       state;
    logic             active;
    logic             cycle_en;
    logic             bus_en;
    logic             instr_done;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    int total  = 0;
    int passed = 0;
    int n_done = 0;

    typedef struct {
        logic        rst, tc, mr, mw, wr;
        logic [31:0] pc;
        logic [2:0]  st;
        logic        act, ce, be, done;
    } vec_t;

    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    mips_cpu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .threecycle (threecycle),
        .memread    (memread),
        .memwrite   (memwrite),
        .waitrequest(waitrequest),
        .pc         (pc),
        .state      (state),
        .active     (active),
        .cycle_en   (cycle_en),
        .bus_en     (bus_en),
        .instr_done (instr_done),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    function automatic vec_t mk(logic rst, logic tc, logic mr, logic mw, logic wr, logic [31:0] p,
                                logic [2:0] st, logic act, logic ce, logic be, logic done);
        vec_t v;
        v.rst = rst; v.tc = tc; v.mr = mr; v.mw = mw; v.wr = wr; v.pc = p;
        v.st = st; v.act = act; v.ce = ce; v.be = be; v.done = done;
        return v;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic tc, logic mr, logic mw, logic wr, logic [31:0] p);
        reset = rst; threecycle = tc; memread = mr; memwrite = mw; waitrequest = wr; pc = p;
    endtask

    // Drive one cycle of inputs, tally instr_done pulses, then advance past the edge.
    task automatic step(logic rst, logic tc, logic mr, logic mw, logic wr, logic [31:0] p);
        drive(rst, tc, mr, mw, wr, p);
        #1;
        if (instr_done === 1'b1) n_done++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1,1,0,0,0,PCV, 3'd1,1,0,0,0);
        vecs[1]  = mk(0,1,1,0,0,PCV, 3'd1,1,1,1,0);
        vecs[2]  = mk(0,1,0,0,0,PCV, 3'd2,1,1,1,0);
        vecs[3]  = mk(0,1,0,0,0,PCV, 3'd3,1,1,1,1);
        vecs[4]  = mk(0,1,1,0,0,PCV, 3'd1,1,1,1,0);
        vecs[5]  = mk(0,1,0,0,0,PCV, 3'd2,1,1,1,0);
        vecs[6]  = mk(0,1,0,0,0,PCV, 3'd3,1,1,1,1);
        vecs[7]  = mk(0,0,1,0,0,PCV, 3'd1,1,1,1,0);
        vecs[8]  = mk(0,0,0,0,0,PCV, 3'd2,1,1,1,0);
        vecs[9]  = mk(0,0,1,0,1,PCV, 3'd3,1,0,1,0);
        vecs[10] = mk(0,0,1,0,1,PCV, 3'd3,1,0,1,0);
        vecs[11] = mk(0,0,1,0,0,PCV, 3'd3,1,1,1,0);
        vecs[12] = mk(0,0,0,0,0,PCV, 3'd4,1,1,1,1);
        vecs[13] = mk(0,0,1,0,0,PCV, 3'd1,1,1,1,0);
        vecs[14] = mk(0,0,0,0,0,PCV, 3'd2,1,1,1,0);
        vecs[15] = mk(0,0,0,0,0,PCV, 3'd3,1,1,1,0);
        vecs[16] = mk(0,0,0,1,1,PCV, 3'd4,1,0,1,0);
        vecs[17] = mk(1,0,0,1,1,PCV, 3'd4,1,0,0,0);
        vecs[18] = mk(0,0,1,0,0,PCV, 3'd1,1,1,1,0);
        vecs[19] = mk(0,0,0,0,0,PCV, 3'd2,1,1,1,0);
        vecs[20] = mk(0,1,0,0,1,PCV, 3'd3,1,1,1,1);
        vecs[21] = mk(0,0,1,0,1,32'h0, 3'd1,1,0,0,0);
        vecs[22] = mk(0,0,1,1,1,32'h0, 3'd0,0,0,0,0);

        drive(1, 1, 0, 0, 0, PCV);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].tc, vecs[i].mr, vecs[i].mw, vecs[i].wr, vecs[i].pc);
            #1;
            check("state",      i, {29'd0, state},      {29'd0, vecs[i].st});
            check("active",     i, {31'd0, active},     {31'd0, vecs[i].act});
            check("cycle_en",   i, {31'd0, cycle_en},   {31'd0, vecs[i].ce});
            check("bus_en",     i, {31'd0, bus_en},     {31'd0, vecs[i].be});
            check("instr_done", i, {31'd0, instr_done}, {31'd0, vecs[i].done});
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 20; i++) begin
            drive(0, i[0], 1, i[1], 1, PCV + i);
            #1;
            check("halt_state",  i, {29'd0, state},  32'd0);
            check("halt_active", i, {31'd0, active}, 32'd0);
            check("halt_bus_en", i, {31'd0, bus_en}, 32'd0);
            @(posedge clk);
            #1;
        end

        step(1, 1, 0, 0, 0, PCV);
        check("rst_state", 0, {29'd0, state}, 32'd1);
        check("rst_cycle_count", 0, cycle_count, 32'd0);
        check("rst_instr_count", 0, instr_count, 32'd0);

        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 0, (i < 4) ? 1'b1 : 1'b0, PCV);
            if (i < 4) step(0, 1, 1, 0, 0, PCV);
            step(0, 1, 0, 0, 0, PCV);
            step(0, 1, 0, 0, 0, PCV);
        end
        check("prog_fetch_state", 0, {29'd0, state}, 32'd1);
        step(0, 1, 1, 0, 1, 32'h0);
        check("prog_halt_state", 0, {29'd0, state}, 32'd0);
        check("prog_instr_done_pulses", 0, n_done, 32'd10);
        check("cycle_count", 0, cycle_count, EXP_CYC);
        check("instr_count", 0, instr_count, EXP_INS);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, PCV);
        check("cycle_count_frozen", 0, cycle_count, EXP_CYC);
        check("instr_count_frozen", 0, instr_count, EXP_INS);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_cpu_sequencer.md
# mips_cpu_sequencer

Multicycle state sequencer for the MIPS CPU. It generates the 3-bit `state` code consumed by the controller: FETCH, DECODE, EXEC1, EXEC2 and HALT. It uses the controller's `threecycle`, `memread` and `memwrite` outputs to pick the instruction length and to stall on the Avalon `waitrequest`. It detects the halt condition (fetch from address 0) and produces the write-enable qualifier that gates all architectural state updates in the datapath.

## Interface
Parameters:
- `CNT_W`, default 32: width of the debug counters.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `threecycle`  in  1  from controller; instruction completes in EXEC1.
- `memread`  in  1  from controller; bus read requested this cycle.
- `memwrite`  in  1  from controller; bus write requested this cycle.
- `waitrequest`  in  1  Avalon stall from memory.
- `pc`  in  32  current program counter from datapath.
- `state`  out  3  encoding: 0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2.
- `active`  out  1  high until HALT is entered.
- `cycle_en`  out  1  qualifies pcwrite/irwrite/regwrite/muldivwrite; low during stall, halt and reset.
- `bus_en`  out  1  qualifies memread/memwrite strobes; low in HALT and during reset.
- `instr_done`  out  1  single-cycle pulse in an instruction's final non-stalled exec cycle.
- `cycle_count`  out  CNT_W  debug cycle counter.
- `instr_count`  out  CNT_W  retired-instruction counter.

## Operation
- `state` is a register. All other outputs are combinational from `state` and the inputs, except the counters, which are registers.
- Stall condition: `stall = (memread | memwrite) & waitrequest & (state != HALT)`.
  - While `stall` is high, `state` holds and `cycle_en` = 0.
  - `bus_en` stays high during a stall so the strobes remain asserted.
- Transitions when not stalled:
  - FETCH → DECODE.
  - DECODE → EXEC1.
  - EXEC1 → FETCH if `threecycle`, else EXEC2.
  - EXEC2 → FETCH.
  - HALT → HALT. HALT is absorbing until reset.
- Halt detect: in FETCH with `pc == 32'h0`:
  - `cycle_en` = 0 and `bus_en` = 0, so no fetch is issued.
  - Next state is HALT regardless of `waitrequest`.
- Illegal encodings 5–7 → HALT next cycle, with `cycle_en` = 0 and `bus_en` = 0.
- `instr_done` = 1 when not stalled and either (EXEC1 & `threecycle`) or EXEC2.
- In HALT: `active` = 0, `cycle_en` = 0, `bus_en` = 0, `instr_done` = 0.

## Timing
- Reset values (on the clock edge with `reset` high, and held while `reset` stays high):
  - `state` = FETCH.
  - Counters = 0.
  - Combinational outputs forced: `active` = 1, `cycle_en` = 0, `bus_en` = 0, `instr_done` = 0.
- First fetch occurs in the first cycle after `reset` deasserts.
- Latency without stalls:
  - 3 cycles when `threecycle`.
  - 4 cycles otherwise (e.g. LW).
- Each stalled cycle adds exactly one cycle. Data is taken in the cycle `waitrequest` is low.
- Simultaneous events:
  - Reset wins over stall and halt.
  - Halt detect wins over stall.
- Reset mid-instruction or mid-stall: `state` = FETCH on the next edge. No partial write is committed, because `cycle_en` = 0 while `reset` is high.
- `active` falls in the first HALT cycle, one cycle after the FETCH with `pc == 0`.

## Configuration
- Macro `MIPS_CPU_PERF_COUNTERS_EN`.
- Defined:
  - `cycle_count` increments every cycle with `reset` low and `state != HALT`, stalls included.
  - `instr_count` increments on `instr_done`.
  - Both wrap modulo 2^CNT_W and freeze in HALT.
- Undefined: both ports stay present and are tied to 0; no counter flops are inferred.

## Structure
- Shared package `mips_cpu_pkg`:
  - `state_t` enum (HALT=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4). The controller uses the same enum.
  - `RESET_VECTOR` constant (32'hBFC00000).
  - `HALT_ADDR` constant (32'h0).
- One sub-module, `mips_cpu_perf_counters`, holds the two counters. It is instantiated only under the macro.

## Test plan
- Reset, `pc` = 32'hBFC00000, `threecycle` = 1, no waitrequest → `state` 1,2,3,1,2,3…; `instr_done` pulses every 3rd cycle; `cycle_en` = 0 in the reset cycle only.
- `threecycle` = 0, `memread` in EXEC1, `waitrequest` high 2 cycles → `state` 1,2,3,3,3,4,1; `cycle_en` low exactly in the 2 stalled cycles; `instr_done` only in EXEC2.
- FETCH with `pc` = 0 and `waitrequest` high → `bus_en` = 0 that cycle; `state` = 0 next cycle; `active` = 0 thereafter for 20 cycles.
- Reset asserted in EXEC2 during a stall → next `state` = 1; `cycle_en` = 0 while reset is high; `instr_done` never pulses.
- With macro: 10 three-cycle instructions plus 4 stall cycles then halt → `instr_count` = 10 and `cycle_count` = 35 (30 instruction cycles, 4 stall cycles, 1 halting FETCH cycle), both frozen afterwards. Without macro: both read 0.
